reg_file_debug_port: RTL and testbench

Debug initiator for `dev_reg_file`: drives the register-file interface from the opposite side to the CPU datapath, so a host can read, write or dump ULM registers over simple valid/ready command and response channels. It sits between the host-link byte deframer (upstream) and the register file, and is muxed onto the interface while the CPU is halted. All register-file accesses are sequenced by an internal FSM; only one access is ever in flight.

---
 rtl/reg_file_debug_port.sv | 203 ++++++++++++++++++++
 tb/tb_reg_file_debug_port.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_debug_port.sv
// Debug initiator for the ULM register file: host read/write/dump over valid/ready channels.
// Optional register dump sequencing is compiled in with `define REG_DBG_DUMP_EN.
package pkg_reg;
  localparam int REG_WIDTH = 32;
  localparam int REG_DEPTH = 16;
  typedef enum logic {REG_READ = 1'b0, REG_WRITE = 1'b1} reg_op_e;
endpackage

interface if_dev_reg_file #(
  parameter int REG_WIDTH = pkg_reg::REG_WIDTH,
  parameter int REG_DEPTH = pkg_reg::REG_DEPTH
);
  localparam int AW = $clog2(REG_DEPTH);
  pkg_reg::reg_op_e     op;
  logic [AW-1:0]        addr_in;
  logic [REG_WIDTH-1:0] data_in;
  logic [AW-1:0]        addr_out0;
  logic [AW-1:0]        addr_out1;
  logic [REG_WIDTH-1:0] data_out0;
  modport initiator (output op, addr_in, data_in, addr_out0, addr_out1, input data_out0);
  modport target (input op, addr_in, data_in, addr_out0, addr_out1, output data_out0);
endinterface

module reg_file_debug_port #(
  parameter int REG_WIDTH = pkg_reg::REG_WIDTH,
  parameter int REG_DEPTH = pkg_reg::REG_DEPTH,
  localparam int AW = $clog2(REG_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [REG_WIDTH-1:0] cmd_data,
  input  logic                 dump_start,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [AW-1:0]        rsp_addr,
  output logic [REG_WIDTH-1:0] rsp_data,
  output logic                 busy,
  if_dev_reg_file.initiator    reg_file
);
  import pkg_reg::*;

`ifdef REG_DBG_DUMP_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, WRITE = 3'd1, READ = 3'd2, RESP = 3'd3, DUMP_READ = 3'd4, DUMP_RESP = 3'd5
  } state_e;
  localparam logic [AW-1:0] PTR_LAST = AW'(REG_DEPTH - 1);
  logic [AW-1:0] ptr_r;
  logic          dump_go_s;
  logic          dump_adv_s;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, RESP = 2'd3} state_e;
  logic unused_dump_s;
  assign unused_dump_s = dump_start;
`endif

  state_e               state_r;
  state_e               state_next_s;
  logic                 accept_s;
  logic                 capture_s;
  logic                 rsp_pending_s;
  logic                 cmd_ready_r;
  logic                 busy_r;
  logic                 rsp_valid_r;
  logic [AW-1:0]        rsp_addr_r;
  logic [REG_WIDTH-1:0] rsp_data_r;
  reg_op_e              op_r;
  logic [AW-1:0]        addr_r;
  logic [REG_WIDTH-1:0] data_r;
  logic [AW-1:0]        addr_out0_r;

  // Next-state decode and per-state strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
`ifdef REG_DBG_DUMP_EN
    dump_go_s    = 1'b0;
    dump_adv_s   = 1'b0;
`endif
    case (state_r)
      IDLE: begin
`ifdef REG_DBG_DUMP_EN
        // A dump request takes priority and leaves a concurrent command unaccepted.
        if (dump_start) begin
          dump_go_s    = 1'b1;
          state_next_s = DUMP_READ;
        end else if (cmd_valid) begin
          accept_s     = 1'b1;
          state_next_s = cmd_write ? WRITE : READ;
        end else begin
          state_next_s = IDLE;
        end
`else
        if (cmd_valid) begin
          accept_s     = 1'b1;
          state_next_s = cmd_write ? WRITE : READ;
        end else begin
          state_next_s = IDLE;
        end
`endif
      end
      WRITE: state_next_s = IDLE;
      READ: begin
        capture_s    = 1'b1;
        state_next_s = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
`ifdef REG_DBG_DUMP_EN
      DUMP_READ: begin
        capture_s    = 1'b1;
        state_next_s = DUMP_RESP;
      end
      DUMP_RESP: begin
        if (rsp_ready && (ptr_r == PTR_LAST)) begin
          state_next_s = IDLE;
        end else if (rsp_ready) begin
          dump_adv_s   = 1'b1;
          state_next_s = DUMP_READ;
        end else begin
          state_next_s = DUMP_RESP;
        end
      end
`endif
      default: state_next_s = IDLE;
    endcase
  end

  // Response-valid is derived from the upcoming state so it is registered with it.
  always_comb begin
`ifdef REG_DBG_DUMP_EN
    rsp_pending_s = (state_next_s == RESP) || (state_next_s == DUMP_RESP);
`else
    rsp_pending_s = (state_next_s == RESP);
`endif
  end

  // State, status flags and all register-file drive values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_addr_r  <= {AW{1'b0}};
      rsp_data_r  <= {REG_WIDTH{1'b0}};
      op_r        <= REG_READ;
      addr_r      <= {AW{1'b0}};
      data_r      <= {REG_WIDTH{1'b0}};
      addr_out0_r <= {AW{1'b0}};
`ifdef REG_DBG_DUMP_EN
      ptr_r       <= {AW{1'b0}};
`endif
    end else begin
      state_r     <= state_next_s;
      cmd_ready_r <= (state_next_s == IDLE);
      busy_r      <= (state_next_s != IDLE);
      rsp_valid_r <= rsp_pending_s;
      op_r        <= (state_next_s == WRITE) ? REG_WRITE : REG_READ;
      if (accept_s) begin
        addr_r      <= cmd_addr;
        data_r      <= cmd_data;
        addr_out0_r <= cmd_addr;
      end
      // addr_out0_r holds the read address in both READ and DUMP_READ.
      if (capture_s) begin
        rsp_data_r <= reg_file.data_out0;
        rsp_addr_r <= addr_out0_r;
      end
`ifdef REG_DBG_DUMP_EN
      if (dump_go_s) begin
        ptr_r       <= {AW{1'b0}};
        addr_out0_r <= {AW{1'b0}};
      end
      if (dump_adv_s) begin
        ptr_r       <= ptr_r + {{(AW-1){1'b0}}, 1'b1};
        addr_out0_r <= ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
`endif
    end
  end

  assign cmd_ready          = cmd_ready_r;
  assign busy               = busy_r;
  assign rsp_valid          = rsp_valid_r;
  assign rsp_addr           = rsp_addr_r;
  assign rsp_data           = rsp_data_r;
  assign reg_file.op        = op_r;
  assign reg_file.addr_in   = addr_r;
  assign reg_file.data_in   = data_r;
  assign reg_file.addr_out0 = addr_out0_r;
  assign reg_file.addr_out1 = {AW{1'b0}};

endmodule

// File: tb/tb_reg_file_debug_port.sv
// Self-checking bench for reg_file_debug_port with a behavioural register file and a
// response scoreboard; covers the dump path when REG_DBG_DUMP_EN is defined.
module tb_reg_file_debug_port;
  import pkg_reg::*;
  localparam int W  = pkg_reg::REG_WIDTH;
  localparam int D  = pkg_reg::REG_DEPTH;
  localparam int AW = $clog2(D);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [W-1:0]  cmd_data;
  logic          dump_start;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [AW-1:0] rsp_addr;
  logic [W-1:0]  rsp_data;
  logic          busy;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [W-1:0] shadow [D];

  if_dev_reg_file #(.REG_WIDTH(W), .REG_DEPTH(D)) rf ();

  // Behavioural register file: synchronous write, asynchronous read, register 0 reads zero.
  logic [W-1:0] regs [D];
  always_ff @(posedge clk) begin
    if (rf.op == REG_WRITE) regs[rf.addr_in] <= rf.data_in;
  end
  assign rf.data_out0 = (rf.addr_out0 == {AW{1'b0}}) ? {W{1'b0}} : regs[rf.addr_out0];

  reg_file_debug_port #(.REG_WIDTH(W), .REG_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .dump_start(dump_start),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .busy(busy), .reg_file(rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || rf.op !== REG_READ) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b busy=%b op=%0d, want 1 0 0 0",
               cmd_ready, rsp_valid, busy, rf.op);
    end
    checks++;
    if (rsp_addr !== {AW{1'b0}} || rsp_data !== {W{1'b0}} || rf.addr_out1 !== {AW{1'b0}}) begin
      errors++;
      $display("FAIL reset_rsp: addr=%0d data=%h addr_out1=%0d, want 0 0 0",
               rsp_addr, rsp_data, rf.addr_out1);
    end
  endtask

  task automatic run_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready_idle: cmd_ready=%b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'b0;
    checks++;
    if (rf.op !== REG_WRITE || rf.addr_in !== a || rf.data_in !== d) begin
      errors++;
      $display("FAIL wr_issue: op=%0d addr=%0d data=%h, want 1 %0d %h", rf.op, rf.addr_in, rf.data_in, a, d);
    end
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_busy: ready=%b busy=%b, want 0 1", cmd_ready, busy);
    end
    shadow[a] = d;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rf.op !== REG_READ) begin
      errors++;
      $display("FAIL wr_done: ready=%b busy=%b op=%0d, want 1 0 0", cmd_ready, busy, rf.op);
    end
  endtask

  task automatic run_read(input logic [AW-1:0] a, input int hold, input logic with_dump);
    exp_t e;
    e.addr = a;
    e.data = (a == {AW{1'b0}}) ? {W{1'b0}} : shadow[a];
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_data = 32'hFFFF_FFFF;
    dump_start = with_dump;
    rsp_ready = (hold == 0) ? 1'b1 : 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0; dump_start = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rf.addr_out0 !== a || busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_addr: valid=%b addr_out0=%0d busy=%b, want 0 %0d 1", rsp_valid, rf.addr_out0, busy, a);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_latency: rsp_valid=%b want 1 two cycles after handshake", rsp_valid);
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL rd_scoreboard: response with empty scoreboard");
    end else begin
      e = sb.pop_front();
      checks++;
      if (rsp_addr !== e.addr || rsp_data !== e.data) begin
        errors++;
        $display("FAIL rd_data: addr=%0d data=%h, want %0d %h", rsp_addr, rsp_data, e.addr, e.data);
      end
    end
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_addr !== e.addr || rsp_data !== e.data || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL rd_stall: valid=%b addr=%0d data=%h ready=%b, want 1 %0d %h 0",
                 rsp_valid, rsp_addr, rsp_data, cmd_ready, e.addr, e.data);
      end
    end
    if (hold > 0) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== e.data) begin
        errors++;
        $display("FAIL rd_hold_end: valid=%b data=%h, want 1 %h", rsp_valid, rsp_data, e.data);
      end
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_release: ready=%b valid=%b, want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_write_read();
    run_write(4'd5, 32'hDEAD_BEEF);
    run_read(4'd5, 0, 1'b0);
  endtask

  task automatic test_reg0();
    run_write(4'd0, 32'h0000_1234);
    run_read(4'd0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_write(4'd3, 32'hA5A5_0003);
    run_read(4'd3, 5, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    run_write(4'd7, 32'h0000_0077);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd7; cmd_data = 32'h0000_00FF;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'b0;
    checks++;
    if (rf.op !== REG_WRITE) begin
      errors++;
      $display("FAIL rst_pre: op=%0d want 1 in WRITE cycle", rf.op);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rf.op !== REG_READ || busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: op=%0d busy=%b ready=%b valid=%b, want 0 0 1 0", rf.op, busy, cmd_ready, rsp_valid);
    end
    checks++;
    if (rsp_addr !== {AW{1'b0}} || rsp_data !== {W{1'b0}} || rf.addr_in !== {AW{1'b0}} ||
        rf.data_in !== {W{1'b0}} || rf.addr_out0 !== {AW{1'b0}}) begin
      errors++;
      $display("FAIL rst_values: rsp_addr=%0d rsp_data=%h addr_in=%0d data_in=%h addr_out0=%0d, want all 0",
               rsp_addr, rsp_data, rf.addr_in, rf.data_in, rf.addr_out0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_read(4'd7, 0, 1'b0);
  endtask

`ifdef REG_DBG_DUMP_EN
  task automatic test_dump();
    exp_t e;
    int got;
    for (int i = 0; i < D; i++) run_write(AW'(i), W'(16 * i));
    for (int i = 0; i < D; i++) begin
      e.addr = AW'(i);
      e.data = (i == 0) ? {W{1'b0}} : shadow[i];
      sb.push_back(e);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    dump_start = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd9; cmd_data = 32'h0000_0BAD;
    got = 0;
    for (int c = 1; c <= 2 * D; c++) begin
      @(negedge clk);
      dump_start = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
      if (c == 1) begin
        checks++;
        if (rf.op !== REG_READ || busy !== 1'b1 || cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL dump_start: op=%0d busy=%b ready=%b, want 0 1 0", rf.op, busy, cmd_ready);
        end
      end
      if (rsp_valid === 1'b1) begin
        got++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL dump_scoreboard: extra response addr=%0d", rsp_addr);
        end else begin
          e = sb.pop_front();
          if (rsp_addr !== e.addr || rsp_data !== e.data) begin
            errors++;
            $display("FAIL dump_rsp: addr=%0d data=%h, want %0d %h", rsp_addr, rsp_data, e.addr, e.data);
          end
        end
      end
    end
    @(negedge clk);
    checks++;
    if (got != D || busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL dump_end: responses=%0d busy=%b ready=%b valid=%b, want %0d 0 1 0",
               got, busy, cmd_ready, rsp_valid, D);
    end
    run_read(4'd9, 0, 1'b0);
  endtask
`else
  task automatic test_dump_ignored();
    run_read(4'd5, 0, 1'b1);
  endtask
`endif

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = {AW{1'b0}};
    cmd_data = {W{1'b0}}; dump_start = 1'b0; rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_reg0();
    test_backpressure();
    test_reset_mid_write();
`ifdef REG_DBG_DUMP_EN
    test_dump();
`else
    test_dump_ignored();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected responses never seen, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
